// File: rtl/weight_loader_fc.sv
// weight_loader_fc
// Loads one fully-connected layer's packed weight RAM from a byte-serial weight stream.
// The stream arrives in .mem file order: feature-major, with neuron index ascending within
// each feature. Each group of NUM_NEURONS weights is packed into one DATA_WIDTH word and
// written to the RAM at the feature address. The first weight of a group lands in the
// top slot, so the RAM word matches the ROM read layout data[i] = mem[addr*N + N-1-i].
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              pulse that starts a load (ignored unless idle)
//   s_valid/s_data     weight stream beat; accepted when s_valid && s_ready
//   s_ready            high while loading
//   wr_en              single-cycle RAM write strobe
//   wr_addr/wr_data    RAM address and packed word; both hold between writes
//   busy               load in progress (LOAD or FINISH)
//   done               single-cycle pulse together with the final write

module weight_loader_fc #(
    parameter int unsigned NUM_FEATURES = 16,
    parameter int unsigned NUM_NEURONS  = 10,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH   = $clog2(NUM_FEATURES),
    parameter int unsigned DATA_WIDTH   = NUM_NEURONS * WEIGHT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    s_valid,
    input  logic [WEIGHT_WIDTH-1:0] s_data,
    output logic                    s_ready,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned KWidth = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [KWidth-1:0]     KLast = KWidth'(NUM_NEURONS - 1);
    localparam logic [ADDR_WIDTH-1:0] FLast = ADDR_WIDTH'(NUM_FEATURES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StFinish} state_e;

    state_e                  state_q, state_d;
    logic [KWidth-1:0]       k_q, k_d;
    logic [ADDR_WIDTH-1:0]   f_q, f_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    wr_en_q, wr_en_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]   word_next;

    // Shift register including the beat being accepted this cycle; on the last beat of a
    // group this is the complete word, so it is written without an extra cycle.
    assign word_next = (shift_q << WEIGHT_WIDTH) | DATA_WIDTH'(s_data);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        f_d       = f_q;
        shift_d   = shift_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    k_d     = '0;
                    f_d     = '0;
                    shift_d = '0;
                end
            end
            StLoad: begin
                // s_ready is high throughout LOAD, so s_valid alone means accept.
                if (s_valid) begin
                    shift_d = word_next;
                    if (k_q == KLast) begin
                        k_d       = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = f_q;
                        wr_data_d = word_next;
                        if (f_q == FLast) begin
                            state_d = StFinish;
                            done_d  = 1'b1;
                            f_d     = '0;
                        end else begin
                            f_d = f_q + ADDR_WIDTH'(1);
                        end
                    end else begin
                        k_d = k_q + KWidth'(1);
                    end
                end
            end
            StFinish: begin
                // start is deliberately ignored here; it is honoured from the next cycle.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= '0;
            f_q       <= '0;
            shift_q   <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            f_q       <= f_d;
            shift_q   <= shift_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign s_ready = (state_q == StLoad);
    assign busy    = (state_q != StIdle);
    assign wr_en   = wr_en_q;
    assign done    = done_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_weight_loader_fc.sv
// Self-checking bench for weight_loader_fc: randomized stream bubbles and stray inputs,
// checked every cycle against a transaction-level model of the load.

module tb_weight_loader_fc;

    localparam int NF    = 16;
    localparam int NN    = 10;
    localparam int WW    = 8;
    localparam int AW    = 4;
    localparam int DW    = NN * WW;
    localparam int TOTAL = NF * NN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    weight_loader_fc #(
        .NUM_FEATURES (NF),
        .NUM_NEURONS  (NN),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: which phase of a load we are in and which beats have been taken.
    typedef enum {MIdle, MLoad, MFin} mstate_e;
    mstate_e       m_state = MIdle;
    int            m_nacc  = 0;
    logic [WW-1:0] m_beats [TOTAL];
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;

    // Observed RAM contents and event counts.
    logic [DW-1:0] ram [NF];
    int            n_wr   = 0;
    int            n_done = 0;

    // Word for feature a: slot i holds beat N-1-i of that feature's group.
    function automatic logic [DW-1:0] pack(input int a);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < NN; i++) w[i*WW +: WW] = m_beats[a*NN + NN - 1 - i];
        return w;
    endfunction

    task automatic tick();
        logic          st, acc, e_wr, e_done;
        logic [WW-1:0] d;
        int            a;
        @(posedge clk);
        st     = start;
        acc    = s_valid && (m_state == MLoad);
        d      = s_data;
        e_wr   = 1'b0;
        e_done = 1'b0;
        case (m_state)
            MIdle: if (st) begin
                m_state = MLoad;
                m_nacc  = 0;
            end
            MLoad: if (acc) begin
                m_beats[m_nacc] = d;
                m_nacc++;
                if (m_nacc % NN == 0) begin
                    a         = m_nacc / NN - 1;
                    e_wr      = 1'b1;
                    last_addr = AW'(a);
                    last_data = pack(a);
                end
                if (m_nacc == TOTAL) begin
                    m_state = MFin;
                    e_done  = 1'b1;
                end
            end
            default: m_state = MIdle;
        endcase
        #1;
        check("s_ready", DW'(s_ready), DW'(m_state == MLoad));
        check("busy",    DW'(busy),    DW'(m_state != MIdle));
        check("wr_en",   DW'(wr_en),   DW'(e_wr));
        check("done",    DW'(done),    DW'(e_done));
        check("wr_addr", DW'(wr_addr), DW'(last_addr));
        check("wr_data", wr_data,      last_data);
        if (wr_en) begin
            ram[wr_addr] = wr_data;
            n_wr++;
        end
        if (done) n_done++;
    endtask

    task automatic do_reset();
        #1;
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        #1;
        m_state   = MIdle;
        m_nacc    = 0;
        last_addr = '0;
        last_data = '0;
        check("rst_s_ready", DW'(s_ready), '0);
        check("rst_busy",    DW'(busy),    '0);
        check("rst_wr_en",   DW'(wr_en),   '0);
        check("rst_done",    DW'(done),    '0);
        check("rst_wr_addr", DW'(wr_addr), '0);
        check("rst_wr_data", wr_data,      '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Idle cycles with junk on the stream; nothing may be accepted or written.
    task automatic idle_junk(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = WW'($urandom);
            start   = 1'b0;
            tick();
        end
        s_valid = 1'b0;
    endtask

    // One load of beats 0x00..0x9F. pct = chance of s_valid per cycle; start_at re-pulses
    // start while that beat is pending; abort_at resets once that many beats are accepted.
    task automatic run_load(input int pct, input int start_at, input int abort_at);
        int guard;
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = WW'($urandom);
        tick();
        start = 1'b0;
        guard = 0;
        while (m_state != MIdle && guard < 3000) begin
            if (abort_at >= 0 && m_state == MLoad && m_nacc == abort_at) begin
                do_reset();
                return;
            end
            if (m_state == MFin) begin
                s_valid = 1'b1;
                s_data  = WW'($urandom);
                start   = 1'b1;
            end else begin
                s_valid = ($urandom_range(0, 99) < pct);
                s_data  = s_valid ? WW'(m_nacc) : WW'($urandom);
                start   = (m_nacc == start_at);
            end
            tick();
            guard++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (guard >= 3000) check("load_timeout", DW'(1), DW'(0));
    endtask

    task automatic clear_stats();
        n_wr   = 0;
        n_done = 0;
        for (int i = 0; i < NF; i++) ram[i] = 'x;
    endtask

    task automatic check_ram(input string tag);
        check({tag, "_nwr"},   DW'(n_wr),   DW'(NF));
        check({tag, "_ndone"}, DW'(n_done), DW'(1));
        check({tag, "_ram0"},  ram[0],  80'h00010203040506070809);
        check({tag, "_ram7"},  ram[7],  80'h464748494A4B4C4D4E4F);
        check({tag, "_ram15"}, ram[15], 80'h969798999A9B9C9D9E9F);
    endtask

    initial begin
        do_reset();
        idle_junk(4);

        clear_stats();
        run_load(100, -1, -1);
        check_ram("full");
        idle_junk(3);

        clear_stats();
        run_load(60, -1, -1);
        check_ram("gaps");
        idle_junk(3);

        clear_stats();
        run_load(100, 50, -1);
        check_ram("restart");
        idle_junk(2);

        clear_stats();
        run_load(100, -1, 73);
        check("abort_nwr",   DW'(n_wr),   DW'(7));
        check("abort_ndone", DW'(n_done), DW'(0));
        idle_junk(3);
        check("abort_after_nwr", DW'(n_wr), DW'(7));
        clear_stats();
        run_load(100, -1, -1);
        check_ram("reload");
        idle_junk(2);

        clear_stats();
        run_load(100, -1, -1);
        run_load(70, -1, -1);
        check("b2b_nwr",   DW'(n_wr),   DW'(2 * NF));
        check("b2b_ndone", DW'(n_done), DW'(2));
        check("b2b_ram15", ram[15], 80'h969798999A9B9C9D9E9F);
        idle_junk(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
